// File: rtl/audio_frame_buffer_if.sv
`default_nettype none
// audio_frame_buffer_if -- valid/ready sample stream from the frame buffer to the FFT front end. Rev 1.0
interface audio_frame_buffer_if #(
   parameter int WORD_WIDTH = 24
);
   logic [WORD_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/audio_frame_buffer.sv
`default_nettype none
// audio_frame_buffer -- captures one channel into block RAM and replays it as a valid/ready frame. Rev 1.0
// Optional level-triggered arming before capture: define LEVEL_TRIGGER_EN.
module audio_frame_buffer #(
   parameter  int WORD_WIDTH = 24,
   parameter  int ADDR_WIDTH = 13,
   parameter  int NUM_CH     = 2,
   parameter  int THRESH     = 4096,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         new_sample,
   input  logic [NUM_CH*WORD_WIDTH-1:0] in_data,
   input  logic [CH_W-1:0]              ch_sel,
   input  logic                         rec_req,
   input  logic                         play_req,
   input  logic                         abort,
   audio_frame_buffer_if.master         out_if,
   output logic                         frame_start,
   output logic                         rec_done,
   output logic [ADDR_WIDTH:0]          fill_level,
   output logic [2:0]                   state
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_REC  = 3'd2,
      S_FULL = 3'd3,
      S_PLAY = 3'd4
   } state_t;

`ifdef LEVEL_TRIGGER_EN
   localparam state_t REC_ENTRY = S_ARM;
`else
   localparam state_t REC_ENTRY = S_REC;
`endif

   state_t                cur_state, nxt_state;
   logic [CH_W-1:0]       ch_q;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [WORD_WIDTH-1:0] rd_q;
   logic [WORD_WIDTH-1:0] chan [NUM_CH];
   logic [WORD_WIDTH-1:0] sample;
   logic                  out_valid_q, out_last_q;
   logic                  rec_go, play_go, trig, we, re, wr_last, advance;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
      assign chan[k] = in_data[k*WORD_WIDTH +: WORD_WIDTH];
   end

   assign sample = chan[ch_q];

`ifdef LEVEL_TRIGGER_EN
   logic [WORD_WIDTH-1:0] mag;

   // The most-negative code has no positive twin, so it saturates to max positive.
   always_comb begin
      mag = sample;
      if (sample[WORD_WIDTH-1]) begin
         if (sample == {1'b1, {(WORD_WIDTH-1){1'b0}}})
            mag = {1'b0, {(WORD_WIDTH-1){1'b1}}};
         else
            mag = -sample;
      end
   end

   assign trig = (mag >= WORD_WIDTH'(THRESH));
`else
   logic [31:0] unused_thresh;
   assign unused_thresh = 32'(THRESH);
   assign trig          = 1'b0;
`endif

   assign rec_go  = rec_req && !abort && (cur_state != S_PLAY);
   assign we      = new_sample && !abort && !rec_go &&
                    ((cur_state == S_REC) || ((cur_state == S_ARM) && trig));
   assign wr_last = (wr_ptr == ADDR_WIDTH'(DEPTH-1));
   assign advance = (cur_state == S_PLAY) && (!out_valid_q || out_if.out_ready);
   assign re      = advance && !rd_ptr[ADDR_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur_state <= S_IDLE;
      else        cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = cur_state;
      play_go   = 1'b0;
      if (abort) begin
         nxt_state = S_IDLE;
      end else if (rec_go) begin
         nxt_state = REC_ENTRY;
      end else begin
         case (cur_state)
            S_IDLE: ;
            S_ARM, S_REC: if (we) nxt_state = wr_last ? S_FULL : S_REC;
            S_FULL: begin
               if (play_req) begin
                  nxt_state = S_PLAY;
                  play_go   = 1'b1;
               end
            end
            S_PLAY: if (out_valid_q && out_if.out_ready && out_last_q) nxt_state = S_FULL;
            default: nxt_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_level  <= '0;
         rec_done    <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= play_go;
         if (abort) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_level  <= '0;
            rec_done    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end else if (rec_go) begin
            ch_q       <= (32'(ch_sel) < NUM_CH) ? ch_sel : '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            rec_done   <= 1'b0;
         end else begin
            if (we) begin
               wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
               fill_level <= fill_level + (ADDR_WIDTH+1)'(1);
               if (wr_last) rec_done <= 1'b1;
            end
            // The output stage only moves when empty or draining, which holds data during stalls.
            if (play_go) begin
               rd_ptr      <= '0;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end else if (advance) begin
               out_valid_q <= !rd_ptr[ADDR_WIDTH];
               out_last_q  <= (rd_ptr == (ADDR_WIDTH+1)'(DEPTH-1));
               if (re) rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr] <= sample;
      if (re) rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
   end

   assign out_if.out_valid = out_valid_q;
   assign out_if.out_last  = out_last_q;
   assign out_if.out_data  = out_valid_q ? rd_q : '0;
   assign state            = cur_state;
endmodule
`default_nettype wire

// File: tb/tb_audio_frame_buffer.sv
`default_nettype none
// tb_audio_frame_buffer -- randomized self-checking bench against an array model of the stored frame. Rev 1.0
module tb_audio_frame_buffer;
   localparam int WW = 24;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   localparam int NCH = 2;

   logic              clk, rst_n, new_sample, rec_req, play_req, abort;
   logic              frame_start, rec_done;
   logic [NCH*WW-1:0] in_data;
   logic [0:0]        ch_sel;
   logic [AW:0]       fill_level;
   logic [2:0]        state;

   int tests = 0;
   int fails = 0;
   logic [WW-1:0] model_mem [DEPTH];

   audio_frame_buffer_if #(.WORD_WIDTH(WW)) st ();

   audio_frame_buffer #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .THRESH(4096)) dut (
      .clk(clk), .rst_n(rst_n), .new_sample(new_sample), .in_data(in_data), .ch_sel(ch_sel),
      .rec_req(rec_req), .play_req(play_req), .abort(abort), .out_if(st),
      .frame_start(frame_start), .rec_done(rec_done), .fill_level(fill_level), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [WW-1:0] c0, input logic [WW-1:0] c1);
      new_sample = 1'b1;
      in_data    = {c1, c0};
      tick;
      new_sample = 1'b0;
   endtask

   task automatic pulse_rec(input logic ch);
      ch_sel  = ch;
      rec_req = 1'b1;
      tick;
      rec_req = 1'b0;
   endtask

   // Random channel, random data, random gaps between strobes; the model keeps what should be stored.
   task automatic record_frame;
      logic ch;
      logic [WW-1:0] s0, s1;
      ch = 1'($urandom_range(0, 1));
      pulse_rec(ch);
      for (int i = 0; i < DEPTH; i++) begin
         repeat ($urandom_range(0, 2)) tick;
         s0 = WW'($urandom());
         s1 = WW'($urandom());
         model_mem[i] = ch ? s1 : s0;
         strobe(s0, s1);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      tick;
      tests++;
      if (state !== 3'd0 || st.out_valid !== 1'b0 || st.out_last !== 1'b0 || rec_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl state=%0d valid=%b last=%b rec_done=%b want 0 0 0 0",
                  state, st.out_valid, st.out_last, rec_done);
      end
      tests++;
      if (fill_level !== '0 || frame_start !== 1'b0 || st.out_data !== '0) begin
         fails++;
         $display("FAIL reset_data fill=%0d fs=%b data=%h want 0 0 0", fill_level, frame_start, st.out_data);
      end
      rst_n = 1'b1;
      tick;
      tests++;
      if (state !== 3'd0) begin
         fails++;
         $display("FAIL reset_release state=%0d want 0", state);
      end
   endtask

   task automatic test_basic;
      logic [WW-1:0] c0;
      int k, cyc, fs;
      pulse_rec(1'b1);
      tests++;
      if (state !== 3'd2) begin
         fails++;
         $display("FAIL basic_rec_state got %0d want 2", state);
      end
      for (int i = 0; i < DEPTH; i++) begin
         c0 = WW'($urandom());
         model_mem[i] = WW'(24'h10 + i);
         strobe(c0, model_mem[i]);
         tests++;
         if (fill_level !== (AW+1)'(i + 1) || state !== ((i == DEPTH-1) ? 3'd3 : 3'd2)) begin
            fails++;
            $display("FAIL basic_fill i=%0d fill=%0d state=%0d want %0d %0d",
                     i, fill_level, state, i + 1, (i == DEPTH-1) ? 3 : 2);
         end
      end
      tests++;
      if (rec_done !== 1'b1) begin
         fails++;
         $display("FAIL basic_rec_done got %b want 1", rec_done);
      end
      st.out_ready = 1'b1;
      play_req = 1'b1;
      tick;
      play_req = 1'b0;
      tests++;
      if (state !== 3'd4 || frame_start !== 1'b1 || st.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_play_entry state=%0d fs=%b valid=%b want 4 1 0", state, frame_start, st.out_valid);
      end
      k = 0;
      cyc = 0;
      fs = 1;
      while (k < DEPTH && cyc < 40) begin
         tick;
         cyc++;
         if (frame_start) fs++;
         tests++;
         if (!st.out_valid) begin
            fails++;
            $display("FAIL basic_bubble k=%0d valid=%b want 1", k, st.out_valid);
         end else begin
            if (st.out_data !== model_mem[k] || st.out_last !== (k == DEPTH-1)) begin
               fails++;
               $display("FAIL basic_data k=%0d got %h last=%b want %h last=%b",
                        k, st.out_data, st.out_last, model_mem[k], (k == DEPTH-1));
            end
            k++;
         end
      end
      tick;
      tests++;
      if (k != DEPTH || fs != 1 || state !== 3'd3 || st.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_end sent=%0d fs=%0d state=%0d valid=%b want 8 1 3 0", k, fs, state, st.out_valid);
      end
   endtask

   task automatic test_backpressure;
      int k, cyc;
      logic rdy, held, hold_last;
      logic [WW-1:0] hold_data;
      for (int run = 0; run < 3; run++) begin
         if (run == 2) begin
            record_frame;
            tests++;
            if (state !== 3'd3 || fill_level !== (AW+1)'(DEPTH)) begin
               fails++;
               $display("FAIL bp_rerecord state=%0d fill=%0d want 3 8", state, fill_level);
            end
         end
         st.out_ready = 1'b0;
         play_req = 1'b1;
         tick;
         play_req = 1'b0;
         k = 0;
         cyc = 0;
         held = 1'b0;
         hold_data = '0;
         hold_last = 1'b0;
         while (k < DEPTH && cyc < 80) begin
            rdy = (run == 2) ? 1'($urandom_range(0, 1)) : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (held) begin
               tests++;
               if (st.out_valid !== 1'b1 || st.out_data !== hold_data || st.out_last !== hold_last) begin
                  fails++;
                  $display("FAIL bp_hold run=%0d k=%0d valid=%b data=%h want 1 %h", run, k,
                           st.out_valid, st.out_data, hold_data);
               end
            end
            st.out_ready = rdy;
            if (st.out_valid && rdy) begin
               tests++;
               if (st.out_data !== model_mem[k] || st.out_last !== (k == DEPTH-1)) begin
                  fails++;
                  $display("FAIL bp_data run=%0d k=%0d got %h last=%b want %h last=%b",
                           run, k, st.out_data, st.out_last, model_mem[k], (k == DEPTH-1));
               end
               k++;
               held = 1'b0;
            end else if (st.out_valid) begin
               held = 1'b1;
               hold_data = st.out_data;
               hold_last = st.out_last;
            end else begin
               held = 1'b0;
            end
            tick;
            cyc++;
         end
         tests++;
         if (k != DEPTH || state !== 3'd3 || st.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_end run=%0d sent=%0d state=%0d valid=%b want 8 3 0", run, k, state, st.out_valid);
         end
      end
      st.out_ready = 1'b0;
   endtask

   task automatic test_abort;
      pulse_rec(1'b0);
      for (int i = 0; i < 5; i++) strobe(WW'($urandom()), WW'($urandom()));
      tests++;
      if (state !== 3'd2 || fill_level !== (AW+1)'(5)) begin
         fails++;
         $display("FAIL abort_pre state=%0d fill=%0d want 2 5", state, fill_level);
      end
      abort = 1'b1;
      tick;
      abort = 1'b0;
      tests++;
      if (state !== 3'd0 || fill_level !== '0 || rec_done !== 1'b0) begin
         fails++;
         $display("FAIL abort_post state=%0d fill=%0d rec_done=%b want 0 0 0", state, fill_level, rec_done);
      end
      st.out_ready = 1'b1;
      play_req = 1'b1;
      tick;
      play_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (st.out_valid !== 1'b0 || state !== 3'd0) begin
            fails++;
            $display("FAIL abort_play cyc=%0d valid=%b state=%0d want 0 0", i, st.out_valid, state);
         end
         tick;
      end
   endtask

   task automatic test_collision;
      record_frame;
      tests++;
      if (state !== 3'd3 || rec_done !== 1'b1) begin
         fails++;
         $display("FAIL coll_full1 state=%0d rec_done=%b want 3 1", state, rec_done);
      end
      rec_req = 1'b1;
      abort = 1'b1;
      play_req = 1'b1;
      tick;
      rec_req = 1'b0;
      abort = 1'b0;
      play_req = 1'b0;
      tests++;
      if (state !== 3'd0 || rec_done !== 1'b0 || fill_level !== '0) begin
         fails++;
         $display("FAIL coll_abort state=%0d rec_done=%b fill=%0d want 0 0 0", state, rec_done, fill_level);
      end
      record_frame;
      rec_req = 1'b1;
      play_req = 1'b1;
      tick;
      rec_req = 1'b0;
      play_req = 1'b0;
      tests++;
      if (state !== 3'd2 || rec_done !== 1'b0 || fill_level !== '0 || frame_start !== 1'b0) begin
         fails++;
         $display("FAIL coll_rec state=%0d rec_done=%b fill=%0d fs=%b want 2 0 0 0",
                  state, rec_done, fill_level, frame_start);
      end
      abort = 1'b1;
      tick;
      abort = 1'b0;
   endtask

   task automatic test_reset_mid_play;
      int n, cyc;
      record_frame;
      st.out_ready = 1'b1;
      play_req = 1'b1;
      tick;
      play_req = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 3 && cyc < 20) begin
         if (st.out_valid) n++;
         tick;
         cyc++;
      end
      tests++;
      if (n != 3) begin
         fails++;
         $display("FAIL rst_play_xfers got %0d want 3", n);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (st.out_valid !== 1'b0 || st.out_last !== 1'b0 || rec_done !== 1'b0 || state !== 3'd0 ||
          st.out_data !== '0) begin
         fails++;
         $display("FAIL rst_play_async valid=%b last=%b rec_done=%b state=%0d data=%h want all 0",
                  st.out_valid, st.out_last, rec_done, state, st.out_data);
      end
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         tests++;
         if (st.out_valid !== 1'b0 || state !== 3'd0) begin
            fails++;
            $display("FAIL rst_play_after cyc=%0d valid=%b state=%0d want 0 0", i, st.out_valid, state);
         end
      end
      st.out_ready = 1'b0;
   endtask

`ifdef LEVEL_TRIGGER_EN
   task automatic test_level_trigger;
      logic [WW-1:0] seq [4];
      logic [2:0] want_st [4];
      int want_fill [4];
      int k, cyc;
      seq = '{WW'(100), WW'(-4095), WW'(-4096), WW'(5)};
      want_st = '{3'd1, 3'd1, 3'd2, 3'd2};
      want_fill = '{0, 0, 1, 2};
      pulse_rec(1'b0);
      tests++;
      if (state !== 3'd1) begin
         fails++;
         $display("FAIL lt_arm state=%0d want 1", state);
      end
      for (int i = 0; i < 4; i++) begin
         strobe(seq[i], WW'($urandom()));
         tests++;
         if (state !== want_st[i] || fill_level !== (AW+1)'(want_fill[i])) begin
            fails++;
            $display("FAIL lt_seq i=%0d state=%0d fill=%0d want %0d %0d",
                     i, state, fill_level, want_st[i], want_fill[i]);
         end
      end
      model_mem[0] = WW'(-4096);
      model_mem[1] = WW'(5);
      for (int i = 2; i < DEPTH; i++) begin
         model_mem[i] = WW'($urandom());
         strobe(model_mem[i], WW'($urandom()));
      end
      st.out_ready = 1'b1;
      play_req = 1'b1;
      tick;
      play_req = 1'b0;
      k = 0;
      cyc = 0;
      while (k < DEPTH && cyc < 40) begin
         if (st.out_valid) begin
            tests++;
            if (st.out_data !== model_mem[k]) begin
               fails++;
               $display("FAIL lt_data k=%0d got %h want %h", k, st.out_data, model_mem[k]);
            end
            k++;
         end
         tick;
         cyc++;
      end
      tests++;
      if (k != DEPTH) begin
         fails++;
         $display("FAIL lt_count got %0d want 8", k);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      new_sample = 1'b0;
      in_data = '0;
      ch_sel = '0;
      rec_req = 1'b0;
      play_req = 1'b0;
      abort = 1'b0;
      st.out_ready = 1'b0;
      test_reset;
`ifdef LEVEL_TRIGGER_EN
      test_level_trigger;
`else
      test_basic;
      test_backpressure;
      test_abort;
      test_collision;
      test_reset_mid_play;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
